// File: rtl/axi_iso_pkg.sv
// ============================================================================
// axi_iso_pkg : shared state encodings, default constants and width helper
// Revision    : 1.0
// ============================================================================
`default_nettype none

package axi_iso_pkg;

   localparam logic [2:0] ST_RUN     = 3'd0;
   localparam logic [2:0] ST_DRAIN   = 3'd1;
   localparam logic [2:0] ST_ISOLATE = 3'd2;
   localparam logic [2:0] ST_SLEEP   = 3'd3;
   localparam logic [2:0] ST_WAKE    = 3'd4;

   localparam int DEF_MAX_OUTSTANDING = 16;
   localparam int DEF_WAKE_DELAY      = 4;
   localparam int DEF_DRAIN_TIMEOUT   = 1024;

   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/axi_iso_txn_cnt.sv
// ============================================================================
// axi_iso_txn_cnt : saturating up/down transaction counter, optional signed
//                   range, with a one-cycle over/underflow pulse
// Revision        : 1.0
// ============================================================================
`default_nettype none

module axi_iso_txn_cnt #(
   parameter int W           = 5,
   parameter int MAX         = 16,
   parameter bit SIGNED_MODE = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] value,
   output logic         ovf
);

   // Signed mode saturates symmetrically at +/-MAX in two's complement.
   localparam logic [W-1:0] HI = W'(MAX);
   localparam logic [W-1:0] LO = SIGNED_MODE ? W'(-MAX) : '0;

   logic up;
   logic down;

   always_comb begin
      up   = inc & ~dec;
      down = dec & ~inc;
      ovf  = (up & (value == HI)) | (down & (value == LO));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (up && (value != HI)) begin
         value <= value + W'(1);
      end else if (down && (value != LO)) begin
         value <= value - W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/axi_isolate_ctrl.sv
// ============================================================================
// axi_isolate_ctrl : drain / isolate / clock-gate / wake sequencer for the
//                    dual-clock AXI slice. Optional macro AXI_ISO_TIMEOUT_EN.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module axi_isolate_ctrl
   import axi_iso_pkg::*;
#(
   parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter  int WAKE_DELAY      = DEF_WAKE_DELAY,
   parameter  int DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT,
   localparam int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sleep_req_i,
   input  logic             wake_req_i,
   input  logic             incoming_req_i,
   input  logic             aw_valid_i,
   input  logic             aw_ready_i,
   input  logic             ar_valid_i,
   input  logic             ar_ready_i,
   input  logic             w_valid_i,
   input  logic             w_ready_i,
   input  logic             w_last_i,
   input  logic             b_valid_i,
   input  logic             b_ready_i,
   input  logic             r_valid_i,
   input  logic             r_ready_i,
   input  logic             r_last_i,
   output logic             clock_down_o,
   output logic             isolate_o,
   output logic             clk_en_o,
   output logic             sleep_ack_o,
   output logic [CNT_W-1:0] wr_outstanding_o,
   output logic [CNT_W-1:0] rd_outstanding_o,
   output logic             err_o,
   output logic             timeout_o
);

   localparam int WAIT_W = $clog2(WAKE_DELAY + 1);

   if (WAKE_DELAY < 1 || DRAIN_TIMEOUT < 1) begin : g_param_check
      $error("axi_isolate_ctrl: WAKE_DELAY and DRAIN_TIMEOUT must be >= 1");
   end

   logic [2:0]        state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [CNT_W:0]    w_bal;
   logic              aw_hs, ar_hs, wl_hs, b_hs, rl_hs;
   logic              wr_ovf, rd_ovf, wb_ovf;
   logic              drained;
   logic              timeout_hit;

   always_comb begin
      aw_hs   = aw_valid_i & aw_ready_i;
      ar_hs   = ar_valid_i & ar_ready_i;
      wl_hs   = w_valid_i & w_ready_i & w_last_i;
      b_hs    = b_valid_i & b_ready_i;
      rl_hs   = r_valid_i & r_ready_i & r_last_i;
      drained = (wr_outstanding_o == '0) && (rd_outstanding_o == '0) && (w_bal == '0);
   end

   axi_iso_txn_cnt #(.W(CNT_W), .MAX(MAX_OUTSTANDING), .SIGNED_MODE(1'b0)) u_wr_cnt (
      .clk(clk_i), .rst(rst_i), .clr(timeout_hit),
      .inc(aw_hs), .dec(b_hs), .value(wr_outstanding_o), .ovf(wr_ovf)
   );

   axi_iso_txn_cnt #(.W(CNT_W), .MAX(MAX_OUTSTANDING), .SIGNED_MODE(1'b0)) u_rd_cnt (
      .clk(clk_i), .rst(rst_i), .clr(timeout_hit),
      .inc(ar_hs), .dec(rl_hs), .value(rd_outstanding_o), .ovf(rd_ovf)
   );

   // W data may lead its AW, so this balance is allowed to go negative.
   axi_iso_txn_cnt #(.W(CNT_W + 1), .MAX(MAX_OUTSTANDING), .SIGNED_MODE(1'b1)) u_wbal_cnt (
      .clk(clk_i), .rst(rst_i), .clr(timeout_hit),
      .inc(aw_hs), .dec(wl_hs), .value(w_bal), .ovf(wb_ovf)
   );

`ifdef AXI_ISO_TIMEOUT_EN
   localparam int DT_W = $clog2(DRAIN_TIMEOUT + 1);

   logic [DT_W-1:0] drain_cnt;

   always_comb begin
      timeout_hit = (state == ST_DRAIN) && sleep_req_i && !drained &&
                    (drain_cnt == DT_W'(DRAIN_TIMEOUT - 1));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || (state != ST_DRAIN)) begin
         drain_cnt <= '0;
      end else begin
         drain_cnt <= drain_cnt + DT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timeout_o <= 1'b0;
      end else if (timeout_hit) begin
         timeout_o <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_o   = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (sleep_req_i) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!sleep_req_i)                state <= ST_RUN;
               else if (drained || timeout_hit) state <= ST_ISOLATE;
            end
            ST_ISOLATE: begin
               state <= ST_SLEEP;
            end
            ST_SLEEP: begin
               if (wake_req_i || incoming_req_i || !sleep_req_i) begin
                  state    <= ST_WAKE;
                  wait_cnt <= WAIT_W'(WAKE_DELAY - 1);
               end
            end
            ST_WAKE: begin
               if (wait_cnt == '0) state <= ST_RUN;
               else                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   // Gate outputs are a registered decode of the current state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clock_down_o <= 1'b0;
         isolate_o    <= 1'b0;
         clk_en_o     <= 1'b1;
         sleep_ack_o  <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         clock_down_o <= (state != ST_RUN);
         isolate_o    <= (state == ST_ISOLATE) || (state == ST_SLEEP) || (state == ST_WAKE);
         clk_en_o     <= (state != ST_SLEEP);
         sleep_ack_o  <= (state == ST_SLEEP);
         err_o        <= err_o | wr_ovf | rd_ovf | wb_ovf;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_isolate_ctrl.sv
// ============================================================================
// tb_axi_isolate_ctrl : directed self-checking bench for axi_isolate_ctrl
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_axi_isolate_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       sleep_req, wake_req, incoming_req;
   logic       aw_valid, aw_ready, ar_valid, ar_ready;
   logic       w_valid, w_ready, w_last;
   logic       b_valid, b_ready, r_valid, r_ready, r_last;
   logic       clock_down, isolate, clk_en, sleep_ack, err, timeout;
   logic [4:0] wr_out, rd_out;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_isolate_ctrl #(
      .MAX_OUTSTANDING(16),
      .WAKE_DELAY(4),
      .DRAIN_TIMEOUT(8)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .sleep_req_i(sleep_req), .wake_req_i(wake_req), .incoming_req_i(incoming_req),
      .aw_valid_i(aw_valid), .aw_ready_i(aw_ready),
      .ar_valid_i(ar_valid), .ar_ready_i(ar_ready),
      .w_valid_i(w_valid), .w_ready_i(w_ready), .w_last_i(w_last),
      .b_valid_i(b_valid), .b_ready_i(b_ready),
      .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
      .clock_down_o(clock_down), .isolate_o(isolate), .clk_en_o(clk_en),
      .sleep_ack_o(sleep_ack),
      .wr_outstanding_o(wr_out), .rd_outstanding_o(rd_out),
      .err_o(err), .timeout_o(timeout)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_bus();
      aw_valid = 0; aw_ready = 0; ar_valid = 0; ar_ready = 0;
      w_valid  = 0; w_ready  = 0; w_last   = 0;
      b_valid  = 0; b_ready  = 0; r_valid  = 0; r_ready  = 0; r_last = 0;
   endtask

   // One cycle of the selected handshakes, then the bus goes quiet.
   task automatic hs(input bit aw, input bit ar, input bit wl, input bit b, input bit rl);
      aw_valid = aw; aw_ready = aw;
      ar_valid = ar; ar_ready = ar;
      w_valid  = wl; w_ready  = wl; w_last = wl;
      b_valid  = b;  b_ready  = b;
      r_valid  = rl; r_ready  = rl; r_last = rl;
      tick(1);
      clear_bus();
   endtask

   task automatic do_reset();
      rst = 1; sleep_req = 0; wake_req = 0; incoming_req = 0;
      clear_bus();
      tick(2);
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (clock_down !== 1'b0) begin failures++; $display("FAIL reset_clock_down got=%b exp=0", clock_down); end
      checks++; if (isolate    !== 1'b0) begin failures++; $display("FAIL reset_isolate got=%b exp=0", isolate); end
      checks++; if (clk_en     !== 1'b1) begin failures++; $display("FAIL reset_clk_en got=%b exp=1", clk_en); end
      checks++; if ({sleep_ack, err, timeout} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {sleep_ack, err, timeout}); end
      checks++; if ({wr_out, rd_out} !== 10'd0) begin failures++; $display("FAIL reset_counters wr=%0d rd=%0d exp=0/0", wr_out, rd_out); end
      // Mid-sequence reset while traffic is active
      hs(1, 0, 0, 0, 0);
      sleep_req = 1;
      tick(2);
      rst = 1; aw_valid = 1; aw_ready = 1;
      tick(1);
      rst = 0; sleep_req = 0; clear_bus();
      checks++; if ({clock_down, wr_out} !== 6'd0) begin failures++; $display("FAIL midreset got cd=%b wr=%0d exp=0/0", clock_down, wr_out); end
   endtask

   task automatic test_idle_sleep_wake();
      do_reset();
      sleep_req = 1;
      tick(1);
      checks++; if (clock_down !== 1'b0) begin failures++; $display("FAIL idle_e1_clock_down got=%b exp=0", clock_down); end
      tick(1);
      checks++; if ({clock_down, isolate} !== 2'b10) begin failures++; $display("FAIL idle_e2_cd_iso got=%b exp=10", {clock_down, isolate}); end
      tick(1);
      checks++; if ({isolate, sleep_ack} !== 2'b10) begin failures++; $display("FAIL idle_e3_iso_ack got=%b exp=10", {isolate, sleep_ack}); end
      tick(1);
      checks++; if ({sleep_ack, clk_en} !== 2'b10) begin failures++; $display("FAIL idle_e4_ack_clken got=%b exp=10", {sleep_ack, clk_en}); end
      tick(2);
      checks++; if ({sleep_ack, clk_en, isolate} !== 3'b101) begin failures++; $display("FAIL sleep_hold got=%b exp=101", {sleep_ack, clk_en, isolate}); end
      // Wake by pending request at the slice
      incoming_req = 1;
      tick(1);
      checks++; if (clk_en !== 1'b0) begin failures++; $display("FAIL wake_e0_clk_en got=%b exp=0", clk_en); end
      tick(1);
      checks++; if ({clk_en, isolate, sleep_ack} !== 3'b110) begin failures++; $display("FAIL wake_e1 got=%b exp=110", {clk_en, isolate, sleep_ack}); end
      incoming_req = 0; sleep_req = 0;
      tick(3);
      checks++; if (isolate !== 1'b1) begin failures++; $display("FAIL wake_e4_isolate got=%b exp=1", isolate); end
      tick(1);
      checks++; if ({isolate, clock_down, clk_en} !== 3'b001) begin failures++; $display("FAIL wake_e5_release got=%b exp=001", {isolate, clock_down, clk_en}); end
   endtask

   task automatic test_drain_wait();
      do_reset();
      hs(1, 0, 0, 0, 0);
      hs(1, 0, 0, 0, 0);
      sleep_req = 1;
      hs(1, 0, 0, 0, 0);
      tick(3);
      checks++; if (wr_out !== 5'd3) begin failures++; $display("FAIL drain_wr got=%0d exp=3", wr_out); end
      checks++; if ({clock_down, isolate} !== 2'b10) begin failures++; $display("FAIL drain_hold got=%b exp=10", {clock_down, isolate}); end
      hs(0, 0, 1, 1, 0);
      hs(0, 0, 1, 1, 0);
      checks++; if ({wr_out, isolate} !== {5'd1, 1'b0}) begin failures++; $display("FAIL drain_partial wr=%0d iso=%b exp=1/0", wr_out, isolate); end
      hs(0, 0, 1, 1, 0);
      checks++; if (wr_out !== 5'd0) begin failures++; $display("FAIL drain_empty wr=%0d exp=0", wr_out); end
      tick(1);
      checks++; if (isolate !== 1'b0) begin failures++; $display("FAIL drain_iso_early got=%b exp=0", isolate); end
      tick(1);
      checks++; if (isolate !== 1'b1) begin failures++; $display("FAIL drain_iso got=%b exp=1", isolate); end
      sleep_req = 0;
   endtask

   task automatic test_abort();
      do_reset();
      hs(0, 1, 0, 0, 0);
      hs(0, 1, 0, 0, 0);
      sleep_req = 1;
      tick(2);
      checks++; if (clock_down !== 1'b1) begin failures++; $display("FAIL abort_cd_up got=%b exp=1", clock_down); end
      sleep_req = 0;
      tick(2);
      checks++; if ({clock_down, isolate} !== 2'b00) begin failures++; $display("FAIL abort_cd_down got=%b exp=00", {clock_down, isolate}); end
      checks++; if (rd_out !== 5'd2) begin failures++; $display("FAIL abort_rd got=%0d exp=2", rd_out); end
      hs(0, 0, 0, 0, 1);
      hs(0, 0, 0, 0, 1);
      checks++; if ({rd_out, err} !== 6'd0) begin failures++; $display("FAIL abort_rd_drain rd=%0d err=%b exp=0/0", rd_out, err); end
   endtask

   task automatic test_boundary();
      do_reset();
      hs(1, 0, 0, 0, 0);
      hs(1, 0, 0, 1, 0);
      checks++; if ({wr_out, err} !== {5'd1, 1'b0}) begin failures++; $display("FAIL simul_aw_b wr=%0d err=%b exp=1/0", wr_out, err); end
      hs(0, 0, 0, 1, 0);
      hs(0, 0, 0, 1, 0);
      checks++; if ({wr_out, err} !== {5'd0, 1'b1}) begin failures++; $display("FAIL underflow wr=%0d err=%b exp=0/1", wr_out, err); end
      do_reset();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", err); end
      for (int i = 0; i < 16; i++) hs(0, 1, 0, 0, 0);
      checks++; if ({rd_out, err} !== {5'd16, 1'b0}) begin failures++; $display("FAIL rd_full rd=%0d err=%b exp=16/0", rd_out, err); end
      hs(0, 1, 0, 0, 0);
      checks++; if ({rd_out, err} !== {5'd16, 1'b1}) begin failures++; $display("FAIL rd_sat rd=%0d err=%b exp=16/1", rd_out, err); end
   endtask

   task automatic test_timeout();
      do_reset();
      hs(1, 0, 0, 0, 0);
      sleep_req = 1;
      tick(1);
`ifdef AXI_ISO_TIMEOUT_EN
      tick(7);
      checks++; if ({timeout, wr_out} !== {1'b0, 5'd1}) begin failures++; $display("FAIL tmo_before got to=%b wr=%0d exp=0/1", timeout, wr_out); end
      tick(1);
      checks++; if ({timeout, wr_out} !== {1'b1, 5'd0}) begin failures++; $display("FAIL tmo_hit got to=%b wr=%0d exp=1/0", timeout, wr_out); end
      tick(1);
      checks++; if (isolate !== 1'b1) begin failures++; $display("FAIL tmo_isolate got=%b exp=1", isolate); end
`else
      tick(12);
      checks++; if ({timeout, isolate, wr_out} !== {1'b0, 1'b0, 5'd1}) begin failures++; $display("FAIL no_tmo got to=%b iso=%b wr=%0d exp=0/0/1", timeout, isolate, wr_out); end
`endif
      sleep_req = 0;
   endtask

   initial begin
      test_reset();
      test_idle_sleep_wake();
      test_drain_wait();
      test_abort();
      test_boundary();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axi_isolate_ctrl.md
Name: axi_isolate_ctrl

Overview:
Power-management sequencer that sits beside the dual-clock AXI slice master wrapper.
- Drives its clock_down and isolate inputs and consumes its incoming_req output.
- Monitors the master-side AXI handshakes, so the slice is drained before isolation, clock-gated while asleep, and safely woken by traffic or request.

Parameters:
MAX_OUTSTANDING, 16, max tracked outstanding bursts per direction; CNT_W = $clog2(MAX_OUTSTANDING+1)
WAKE_DELAY, 4, cycles between clock re-enable and isolate release (>=1)
DRAIN_TIMEOUT, 1024, drain cycle limit; used only with AXI_ISO_TIMEOUT_EN

Ports:
clk_i  in  1  clock (slice master-side domain)
rst_i  in  1  synchronous, active-high reset
sleep_req_i  in  1  level request to sleep
wake_req_i  in  1  level external wake request
incoming_req_i  in  1  pending AW/AR at slice (incoming_req of wrapper)
aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i  in  1 each  master-side address handshakes
w_valid_i, w_ready_i, w_last_i  in  1 each  master-side write data
b_valid_i, b_ready_i  in  1 each  write response
r_valid_i, r_ready_i, r_last_i  in  1 each  read data
clock_down_o  out  1  to wrapper clock_down_i
isolate_o  out  1  to wrapper isolate_i
clk_en_o  out  1  enable for downstream clock gate
sleep_ack_o  out  1  high only in SLEEP
wr_outstanding_o  out  CNT_W  open write bursts
rd_outstanding_o  out  CNT_W  open read bursts
err_o  out  1  sticky counter over/underflow
timeout_o  out  1  sticky drain timeout (0 without feature)

Behaviour:
- All outputs registered. Reset: state RUN, clock_down_o=0, isolate_o=0, clk_en_o=1, sleep_ack_o=0, counters 0, err_o=0, timeout_o=0. Reset mid-sequence returns to RUN next edge regardless of bus activity.
- wr counter: +1 on aw_valid&aw_ready, -1 on b_valid&b_ready, both in one cycle -> unchanged.
- rd counter: +1 on ar hs, -1 on r hs with r_last.
- w_bal: signed CNT_W+1. +1 on AW hs, -1 on W hs with w_last. Negative allowed, since W may precede AW.
- Increment at MAX_OUTSTANDING saturates; decrement at 0 holds 0. Either case sets err_o until reset.
- drained = wr==0 & rd==0 & w_bal==0, computed from registered values.
- FSM:
  - RUN: all gates off. sleep_req_i=1 -> DRAIN.
  - DRAIN: clock_down_o=1, blocking new AW/AR/W; in-flight responses still flow. sleep_req_i=0 -> RUN (clock_down_o=0 next cycle). drained -> ISOLATE.
  - ISOLATE: isolate_o=1, clock_down_o=1; one cycle -> SLEEP.
  - SLEEP: clk_en_o=0, sleep_ack_o=1. (wake_req_i | incoming_req_i | ~sleep_req_i) -> WAKE.
  - WAKE: clk_en_o=1, isolate_o=1, clock_down_o=1, wait counter loads WAKE_DELAY-1 and decrements; at 0 -> RUN. Wake sources are ignored once in WAKE; re-entry to sleep requires passing through RUN.
- Simultaneous sleep_req_i rise and AW hs in RUN: the handshake is counted, and DRAIN waits for it.
- Counters keep updating in every state. Handshakes seen while isolated (forced ready) still decrement.

Optional Feature:
- Macro: AXI_ISO_TIMEOUT_EN.
  - Defined: a drain cycle counter clears on DRAIN entry. Reaching DRAIN_TIMEOUT cycles forces -> ISOLATE, sets timeout_o (sticky) and clears all counters and w_bal.
  - Undefined: DRAIN waits indefinitely; timeout_o tied 0; no counter logic.

Decomposition:
- Package axi_iso_pkg: state enum (RUN, DRAIN, ISOLATE, SLEEP, WAKE), CNT_W function, default constants.
- One sub-module axi_iso_txn_cnt (saturating up/down counter with err flag), instantiated for wr, rd and w_bal (signed mode).

Test Plan:
- Idle: sleep_req_i=1 with counters 0 -> DRAIN 1 cycle, ISOLATE 1 cycle, SLEEP; sleep_ack_o=1 on 4th edge after request, clk_en_o=0.
- Drain wait: 3 AW hs then sleep_req -> stays DRAIN with wr=3. After 3 B hs plus 3 w_last hs -> ISOLATE the following cycle.
- Abort: sleep_req_i drops while DRAIN with rd=2 -> RUN next cycle, clock_down_o=0, rd still 2.
- Wake: in SLEEP, incoming_req_i=1 -> WAKE, clk_en_o=1. isolate_o falls exactly WAKE_DELAY=4 cycles later, then RUN.
- Boundary: 17 AR hs with MAX_OUTSTANDING=16 -> rd=16, err_o=1. Simultaneous AW and B hs -> wr unchanged.
- Timeout (AXI_ISO_TIMEOUT_EN, DRAIN_TIMEOUT=8): wr=1 never answered -> ISOLATE after 8 DRAIN cycles, timeout_o=1, wr=0.
